// File: rtl/exec_result_buf.sv
// exec_result_buf: two-entry in-order result buffer between the execute
// units and register writeback, with operand forwarding from entries that
// are buffered but not yet written back.
// Optional feature macro: EXEC_RESULT_FWD_EN builds the forwarding
// comparators and muxes; without it the forwarding outputs are tied to zero.
module exec_result_buf #(
  parameter int W_OPR = 32,
  parameter int W_REG = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W_OPR-1:0] in_result_i,
  input  logic [W_REG-1:0] in_dst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W_OPR-1:0] out_result_o,
  output logic [W_REG-1:0] out_dst_o,
  input  logic [W_REG-1:0] fwd_reg_a_i,
  input  logic [W_REG-1:0] fwd_reg_b_i,
  output logic             fwd_hit_a_o,
  output logic             fwd_hit_b_o,
  output logic [W_OPR-1:0] fwd_val_a_o,
  output logic [W_OPR-1:0] fwd_val_b_o,
  output logic [1:0]       count_o
);

  logic [W_OPR-1:0] result_q [2];
  logic [W_OPR-1:0] result_d [2];
  logic [W_REG-1:0] dst_q    [2];
  logic [W_REG-1:0] dst_d    [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic push, pop;

  // Readiness and validity come only from the registered count, so the input
  // side never depends combinationally on the writeback handshake.
  assign in_ready_o   = (count_q != 2'd2);
  assign out_valid_o  = (count_q != 2'd0);
  assign out_result_o = result_q[head_q];
  assign out_dst_o    = dst_q[head_q];
  assign count_o      = count_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // Next-state: write at tail on push, advance head on pop; flush drops everything.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    result_d = result_q;
    dst_d    = dst_q;
    if (flush_i) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        result_d[tail_q] = in_result_i;
        dst_d[tail_q]    = in_dst_i;
        tail_d           = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register; reset clears pointers, count and storage contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        result_q[i] <= '0;
        dst_q[i]    <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      result_q <= result_d;
      dst_q    <= dst_d;
    end
  end

`ifdef EXEC_RESULT_FWD_EN
  // The youngest entry sits just behind the tail; the older one is at the
  // head and is only live when both entries are occupied.
  logic young_idx, young_vld, old_idx, old_vld;

  assign young_idx = ~tail_q;
  assign young_vld = (count_q != 2'd0);
  assign old_idx   = head_q;
  assign old_vld   = (count_q == 2'd2);

  // Forwarding for source A: youngest match wins, r0 never hits.
  always_comb begin
    fwd_hit_a_o = 1'b0;
    fwd_val_a_o = '0;
    if (fwd_reg_a_i != '0) begin
      if (young_vld && (dst_q[young_idx] == fwd_reg_a_i)) begin
        fwd_hit_a_o = 1'b1;
        fwd_val_a_o = result_q[young_idx];
      end else if (old_vld && (dst_q[old_idx] == fwd_reg_a_i)) begin
        fwd_hit_a_o = 1'b1;
        fwd_val_a_o = result_q[old_idx];
      end
    end
  end

  // Forwarding for source B: same priority rule as source A.
  always_comb begin
    fwd_hit_b_o = 1'b0;
    fwd_val_b_o = '0;
    if (fwd_reg_b_i != '0) begin
      if (young_vld && (dst_q[young_idx] == fwd_reg_b_i)) begin
        fwd_hit_b_o = 1'b1;
        fwd_val_b_o = result_q[young_idx];
      end else if (old_vld && (dst_q[old_idx] == fwd_reg_b_i)) begin
        fwd_hit_b_o = 1'b1;
        fwd_val_b_o = result_q[old_idx];
      end
    end
  end
`else
  // Forwarding disabled: outputs held at zero and source indices ignored.
  logic unused_fwd;
  assign unused_fwd  = ^{fwd_reg_a_i, fwd_reg_b_i};
  assign fwd_hit_a_o = 1'b0;
  assign fwd_hit_b_o = 1'b0;
  assign fwd_val_a_o = '0;
  assign fwd_val_b_o = '0;
`endif

endmodule

// File: tb/tb_exec_result_buf.sv
// tb_exec_result_buf: directed and random stimulus for exec_result_buf,
// checked against a queue-based model of the buffer contents.
module tb_exec_result_buf;

  localparam int W_OPR = 32;
  localparam int W_REG = 5;

  typedef struct packed {
    logic [W_REG-1:0] dst;
    logic [W_OPR-1:0] res;
  } entryT;

  logic             clk_i = 1'b0;
  logic             rst_i, flush_i, in_valid_i, out_ready_i;
  logic [W_OPR-1:0] in_result_i;
  logic [W_REG-1:0] in_dst_i, fwd_reg_a_i, fwd_reg_b_i;
  logic             in_ready_o, out_valid_o, fwd_hit_a_o, fwd_hit_b_o;
  logic [W_OPR-1:0] out_result_o, fwd_val_a_o, fwd_val_b_o;
  logic [W_REG-1:0] out_dst_o;
  logic [1:0]       count_o;

  int    assertCount = 0;
  int    failCount   = 0;
  entryT modelQ[$];

`ifdef EXEC_RESULT_FWD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  exec_result_buf #(.W_OPR(W_OPR), .W_REG(W_REG)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_result_i(in_result_i), .in_dst_i(in_dst_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_dst_o(out_dst_o),
    .fwd_reg_a_i(fwd_reg_a_i), .fwd_reg_b_i(fwd_reg_b_i),
    .fwd_hit_a_o(fwd_hit_a_o), .fwd_hit_b_o(fwd_hit_b_o),
    .fwd_val_a_o(fwd_val_a_o), .fwd_val_b_o(fwd_val_b_o),
    .count_o(count_o)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic expectValue(input string tag, input logic [W_OPR-1:0] obs,
                             input logic [W_OPR-1:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Forwarding reference: scan stored entries from youngest to oldest.
  task automatic fwdRef(input logic [W_REG-1:0] r, output logic hit,
                        output logic [W_OPR-1:0] val);
    hit = 1'b0;
    val = '0;
    if (FwdOn && r != '0) begin
      for (int i = modelQ.size() - 1; i >= 0; i--) begin
        if (modelQ[i].dst == r) begin
          hit = 1'b1;
          val = modelQ[i].res;
          break;
        end
      end
    end
  endtask

  // Compare every DUT output with what the model says before the next edge.
  task automatic checkOutput();
    logic             hA, hB;
    logic [W_OPR-1:0] vA, vB;
    fwdRef(fwd_reg_a_i, hA, vA);
    fwdRef(fwd_reg_b_i, hB, vB);
    expectValue("count", {30'b0, count_o}, modelQ.size());
    expectValue("in_ready", {31'b0, in_ready_o}, {31'b0, modelQ.size() < 2});
    expectValue("out_valid", {31'b0, out_valid_o}, {31'b0, modelQ.size() != 0});
    if (modelQ.size() != 0) begin
      expectValue("out_result", out_result_o, modelQ[0].res);
      expectValue("out_dst", {27'b0, out_dst_o}, {27'b0, modelQ[0].dst});
    end
    expectValue("fwd_hit_a", {31'b0, fwd_hit_a_o}, {31'b0, hA});
    expectValue("fwd_val_a", fwd_val_a_o, vA);
    expectValue("fwd_hit_b", {31'b0, fwd_hit_b_o}, {31'b0, hB});
    expectValue("fwd_val_b", fwd_val_b_o, vB);
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance the
  // model at the rising edge using the occupancy seen before that edge.
  task automatic applyStimulus(input bit r, input bit f, input bit iv,
                               input logic [W_OPR-1:0] res,
                               input logic [W_REG-1:0] d, input bit ordy,
                               input logic [W_REG-1:0] fa,
                               input logic [W_REG-1:0] fb);
    bit canPush, doPop;
    entryT e;
    @(negedge clk_i);
    rst_i = r; flush_i = f; in_valid_i = iv; in_result_i = res;
    in_dst_i = d; out_ready_i = ordy; fwd_reg_a_i = fa; fwd_reg_b_i = fb;
    #1;
    checkOutput();
    @(posedge clk_i);
    if (r || f) begin
      modelQ.delete();
    end else begin
      canPush = (modelQ.size() < 2);
      doPop   = (modelQ.size() != 0) && ordy;
      if (doPop) void'(modelQ.pop_front());
      if (iv && canPush) begin
        e.dst = d;
        e.res = res;
        modelQ.push_back(e);
      end
    end
    #1;
  endtask

  // All outputs at their documented reset values, storage cleared to zero.
  task automatic checkResetValues();
    expectValue("rst_in_ready", {31'b0, in_ready_o}, 1);
    expectValue("rst_out_valid", {31'b0, out_valid_o}, 0);
    expectValue("rst_out_result", out_result_o, 0);
    expectValue("rst_out_dst", {27'b0, out_dst_o}, 0);
    expectValue("rst_count", {30'b0, count_o}, 0);
    expectValue("rst_hit_a", {31'b0, fwd_hit_a_o}, 0);
    expectValue("rst_hit_b", {31'b0, fwd_hit_b_o}, 0);
    expectValue("rst_val_a", fwd_val_a_o, 0);
    expectValue("rst_val_b", fwd_val_b_o, 0);
  endtask

  // Directed scenarios followed by a randomized run, then the summary.
  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_result_i = '0; in_dst_i = '0; fwd_reg_a_i = '0; fwd_reg_b_i = '0;
    @(posedge clk_i);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkResetValues();

    // Fill to two entries with writeback stalled; third push is refused.
    applyStimulus(0, 0, 1, 32'h0000_00F0, 3, 0, 3, 4);
    applyStimulus(0, 0, 1, 32'hFFFF_FF00, 4, 0, 3, 4);
    expectValue("full_count", {30'b0, count_o}, 2);
    expectValue("full_in_ready", {31'b0, in_ready_o}, 0);
    applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 9, 0, 9, 0);
    expectValue("third_count", {30'b0, count_o}, 2);
    expectValue("third_head", {27'b0, out_dst_o}, 3);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    expectValue("drain_first", {27'b0, out_dst_o}, 4);
    expectValue("drain_ready", {31'b0, in_ready_o}, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    expectValue("drain_empty", {31'b0, out_valid_o}, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

    // Two results to r7: the younger value must be forwarded; r0 never hits.
    applyStimulus(0, 0, 1, 32'h11, 7, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h22, 7, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
    fwd_reg_a_i = 7; fwd_reg_b_i = 0; #1;
    expectValue("fwd7_hit_a", {31'b0, fwd_hit_a_o}, {31'b0, FwdOn});
    expectValue("fwd7_val_a", fwd_val_a_o, FwdOn ? 32'h22 : 32'h0);
    expectValue("fwd7_hit_b", {31'b0, fwd_hit_b_o}, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    // Result aimed at r0 is still buffered and delivered.
    applyStimulus(0, 0, 1, 32'h55, 0, 0, 0, 0);
    expectValue("r0_valid", {31'b0, out_valid_o}, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

    // Streaming with writeback always ready: occupancy stays at one.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 1, 32'h100 + i, 5'(i), 1, 5'(i), 5'(i - 1));
      expectValue("stream_count", {30'b0, count_o}, 1);
      expectValue("stream_dst", {27'b0, out_dst_o}, i);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

    // Flush at full with a simultaneous push and pop: all gone.
    applyStimulus(0, 0, 1, 32'hA, 10, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'hB, 11, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'hC, 12, 1, 12, 11);
    expectValue("flush_count", {30'b0, count_o}, 0);
    expectValue("flush_valid", {31'b0, out_valid_o}, 0);
    expectValue("flush_ready", {31'b0, in_ready_o}, 1);

    // Reset at count one with a push in flight.
    applyStimulus(0, 0, 1, 32'hE, 13, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'hF, 14, 0, 0, 0);
    fwd_reg_a_i = 13; fwd_reg_b_i = 14; #1;
    checkResetValues();

    // Random traffic with a small register range so forwarding hits often.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(39) == 0),
                    $urandom_range(3) != 0, $urandom,
                    5'($urandom_range(7)), $urandom_range(2) != 0,
                    5'($urandom_range(7)), 5'($urandom_range(7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/exec_result_buf.md
# exec_result_buf

Two-entry result buffer between the execute units (shifter, ALU) and register writeback. It accepts one result per cycle with its destination register index over a valid/ready handshake and holds it in order. It presents results to writeback over a second valid/ready handshake, so a writeback stall does not drop an in-flight result. It also supplies operand forwarding from buffered, not-yet-written results back to the decode/operand-select stage.

## Interface

Parameters:
- W_OPR, 32, operand/result width
- W_REG, 5, register index width

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  synchronous discard of all buffered entries
- in_valid_i  in  1  execute result valid
- in_ready_o  out  1  buffer can accept a result this cycle
- in_result_i  in  W_OPR  execute result
- in_dst_i  in  W_REG  destination register index
- out_valid_o  out  1  head entry valid toward writeback
- out_ready_i  in  1  writeback accepts head entry
- out_result_o  out  W_OPR  head result
- out_dst_o  out  W_REG  head destination index
- fwd_reg_a_i, fwd_reg_b_i  in  W_REG  source register indices being read by decode
- fwd_hit_a_o, fwd_hit_b_o  out  1  a buffered entry matches the source index
- fwd_val_a_o, fwd_val_b_o  out  W_OPR  forwarded value
- count_o  out  2  number of valid entries (0..2)

## Operation

- Storage: 2 entries {result, dst}, circular. Head pointer, tail pointer and count registers.
- Push: in_valid_i & in_ready_o writes the entry at the tail, then the tail advances modulo 2.
- Pop: out_valid_o & out_ready_i advances the head modulo 2.
- in_ready_o = (count_o != 2). It depends only on registered state, never on out_ready_i.
- out_valid_o = (count_o != 0). out_result_o and out_dst_o show the head entry.
- Output fields are stable while out_valid_o=1 and out_ready_i=0.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop. This is legal only at count 1, because at count 2 push is blocked.
- Flush: count, head and tail go to 0 at the next edge. Flush wins over a same-cycle push and pop. The pushed beat is discarded, and the popped beat counts as consumed by writeback.
- Forwarding, combinational:
  - Compares fwd_reg_x_i against the dst of each valid entry.
  - On multiple matches, the youngest entry (nearest the tail) wins.
  - dst 0 never hits, because r0 is hardwired zero.
  - On no hit: fwd_hit_x_o=0 and fwd_val_x_o=0.
  - The incoming in_result_i beat is not forwarded; only stored entries are.
- Results with dst 0 are still buffered and delivered to writeback.

## Timing

- Reset values: in_ready_o=1, out_valid_o=0, out_result_o=0, out_dst_o=0, count_o=0, all fwd_hit_*=0, all fwd_val_*=0. Storage contents are cleared to 0.
- Reset asserted mid-operation discards all entries at that edge. Reset has priority over flush, push and pop.
- Latency: a result pushed at edge N is visible at out_valid_o after edge N and is forwardable from the cycle after edge N.
- Throughput: 1 result/cycle sustained while out_ready_i=1.
- Full (count 2): in_ready_o=0. After a pop at edge N, in_ready_o=1 in the cycle after N. There is no same-cycle pass-through.
- Empty (count 0) with out_ready_i=1: no pop occurs and the head does not move.
- Pointer wrap: 1 → 0 on each of head and tail independently.
- Forwarding outputs reflect the entries registered at the most recent edge.

## Configuration

- EXEC_RESULT_FWD_EN defined:
  - The comparators and forwarding muxes are built.
  - fwd_hit_*/fwd_val_* behave as in Operation.
- EXEC_RESULT_FWD_EN undefined:
  - The ports remain present, but fwd_hit_a_o, fwd_hit_b_o, fwd_val_a_o and fwd_val_b_o are tied to 0.
  - fwd_reg_*_i are ignored.
  - No comparator logic is synthesized.
  - Buffering behaviour is unchanged.

## Test plan

- Push 0x000000F0/dst 3 with out_ready_i=0, then 0xFFFFFF00/dst 4. Required:
  - count_o=2 and in_ready_o=0.
  - A third push is not accepted.
  - Raising out_ready_i delivers dst 3 first, then dst 4.
- Push 0x11/dst 7 and 0x22/dst 7, then query fwd_reg_a_i=7, fwd_reg_b_i=0. Required:
  - fwd_hit_a_o=1 with fwd_val_a_o=0x22.
  - fwd_hit_b_o=0.
  - With the macro undefined, both hits are 0.
- Hold out_ready_i=1 and push every cycle for 8 cycles with dst 1..8. Required:
  - count_o stays 1.
  - Writeback sees dst 1..8 in order, one per cycle, after a 1-cycle start latency.
- At count 2, assert flush_i together with in_valid_i=1 and out_ready_i=1. Required: next cycle count_o=0, out_valid_o=0 and in_ready_o=1, and the pushed beat is absent.
- Assert rst_i at count 1 with in_valid_i=1. Required: after the edge all outputs are at their reset values and the pushed beat is absent.
